// File: rtl/position_alert_sched.sv
// Position-button alert scheduler: synchronise and debounce five buttons, queue rising presses,
// serve them round-robin as i+1 buzzer beeps. Optional macro POS_SEAT_PRIORITY_EN gives the seat (index 4) priority.
module position_alert_sched #(
  parameter int DEB_CYC      = 500000,
  parameter int BEEP_ON_CYC  = 5000000,
  parameter int BEEP_OFF_CYC = 5000000,
  parameter int GAP_CYC      = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] pos_btn,
  output logic [4:0] led,
  output logic       buzz_en,
  output logic       busy,
  output logic [2:0] cur_id
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int ONW  = $clog2(BEEP_ON_CYC + 1);
  localparam int OFFW = $clog2(BEEP_OFF_CYC + 1);
  localparam int GAPW = $clog2(GAP_CYC + 1);
  localparam int TW0  = (ONW > OFFW) ? ONW : OFFW;
  localparam int TW   = (TW0 > GAPW) ? TW0 : GAPW;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(BEEP_ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(BEEP_OFF_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [4:0]    sync1, sync2, led_d, pending, rise, gnt_mask;
  logic [DW-1:0] deb_cnt [5];
  logic [1:0]    state;
  logic [TW-1:0] tmr;
  logic [2:0]    beeps_left, rr, gnt_idx;
  logic          gnt_vld;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 5) s = s - 5;
    return 3'(s);
  endfunction

  // Sync, debounce and rise detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      led   <= '0;
      led_d <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= pos_btn;
      sync2 <= sync1;
      led_d <= led;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != led[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            led[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = led & ~led_d;

  // Lowest offset from the rr pointer wins; seat override applied last
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (pending[wrap_idx(rr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr, k);
      end
    end
`ifdef POS_SEAT_PRIORITY_EN
    if (pending[4]) begin
      gnt_vld = 1'b1;
      gnt_idx = 3'd4;
    end
`else
`endif
  end

  assign gnt_mask = (state == S_IDLE && gnt_vld) ? (5'b00001 << gnt_idx) : 5'b00000;
  assign busy     = (state != S_IDLE);

  // Beep sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmr        <= '0;
      beeps_left <= 3'd0;
      rr         <= 3'd0;
      cur_id     <= 3'd0;
      buzz_en    <= 1'b0;
      pending    <= '0;
    end else begin
      pending <= (pending & ~gnt_mask) | rise;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            state      <= S_ON;
            cur_id     <= gnt_idx;
            beeps_left <= gnt_idx + 3'd1;
            rr         <= wrap_idx(gnt_idx, 1);
            tmr        <= '0;
            buzz_en    <= 1'b1;
          end
        end
        S_ON: begin
          if (tmr == ON_LAST) begin
            tmr     <= '0;
            buzz_en <= 1'b0;
            if (beeps_left > 3'd1) begin
              beeps_left <= beeps_left - 3'd1;
              state      <= S_OFF;
            end else begin
              state <= S_GAP;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_OFF: begin
          if (tmr == OFF_LAST) begin
            tmr     <= '0;
            state   <= S_ON;
            buzz_en <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr    <= '0;
            state  <= S_IDLE;
            cur_id <= 3'd0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_position_alert_sched.sv
// Bench for position_alert_sched: alert-schedule reference model checked every cycle, plus directed literal checks.
module tb_position_alert_sched;
  localparam int DEB = 4, ON = 3, OFF = 2, GAP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pos_btn = 5'd0;
  logic [4:0] led;
  logic       buzz_en, busy;
  logic [2:0] cur_id;

  position_alert_sched #(.DEB_CYC(DEB), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .pos_btn(pos_btn), .led(led),
    .buzz_en(buzz_en), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: debounce by counting differing cycles, alerts as precomputed output schedules
  logic [4:0] m_s1, m_s2, m_led, m_ledp, m_pend, m_rise;
  int         m_dc [5];
  int         m_rr, m_g;
  logic       m_buzz, m_busy;
  logic [2:0] m_cur;
  logic [4:0] sched[$];

  function automatic int pick(input logic [4:0] p, input int rr);
`ifdef POS_SEAT_PRIORITY_EN
    if (p[4]) return 4;
`else
`endif
    for (int k = 0; k < 5; k++) if (p[(rr + k) % 5]) return (rr + k) % 5;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_led = 0; m_ledp = 0; m_pend = 0; m_rr = 0;
      m_buzz = 0; m_busy = 0; m_cur = 0;
      for (int i = 0; i < 5; i++) m_dc[i] = 0;
      sched.delete();
    end else begin
      m_rise = m_led & ~m_ledp;
      m_ledp = m_led;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_led[i]) begin
          m_dc[i]++;
          if (m_dc[i] == DEB) begin m_led[i] = m_s2[i]; m_dc[i] = 0; end
        end else m_dc[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = pos_btn;
      m_g = -1;
      if (!m_busy && m_pend != 0) begin
        m_g = pick(m_pend, m_rr);
        m_rr = (m_g + 1) % 5;
        for (int b = 0; b <= m_g; b++) begin
          repeat (ON) sched.push_back({1'b1, 3'(m_g), 1'b1});
          if (b < m_g) repeat (OFF) sched.push_back({1'b0, 3'(m_g), 1'b1});
        end
        repeat (GAP) sched.push_back({1'b0, 3'(m_g), 1'b1});
      end
      if (sched.size() > 0) {m_buzz, m_cur, m_busy} = sched.pop_front();
      else begin m_buzz = 0; m_cur = 0; m_busy = 0; end
      m_pend = (m_pend & ~((m_g >= 0) ? (5'd1 << m_g) : 5'd0)) | m_rise;
    end
  end

  // Per-cycle compare plus bookkeeping for the directed checks
  int   beeps, buzz_cycles, ord_code;
  logic prev_buzz, prev_busy, led_seen, buzz_seen;

  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle_outputs", int'({led, buzz_en, busy, cur_id}), int'({m_led, m_buzz, m_busy, m_cur}));
      if (buzz_en && !prev_buzz) beeps++;
      if (busy && !prev_busy) ord_code = ord_code * 10 + int'(cur_id) + 1;
      if (led != 0) led_seen = 1;
      if (buzz_en) begin buzz_seen = 1; buzz_cycles++; end
      prev_buzz = buzz_en;
      prev_busy = busy;
    end else begin
      prev_buzz = 0;
      prev_busy = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_book();
    beeps = 0; buzz_cycles = 0; ord_code = 0; led_seen = 0; buzz_seen = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 0;
    pos_btn = 0;
    cyc(3);
    rst_n = 1;
    clear_book();
  endtask

  initial begin
    int n;
    clear_book();
    cyc(2);
    check("reset_outputs", int'({led, buzz_en, busy, cur_id}), 0);
    rst_n = 1;

    // Short glitch is filtered
    pos_btn = 5'b00100;
    cyc(3);
    pos_btn = 5'b00000;
    cyc(20);
    check("glitch_led_seen", int'(led_seen), 0);
    check("glitch_buzz_seen", int'(buzz_seen), 0);

    // Held button: latency, beep pattern for index 2
    do_reset();
    pos_btn = 5'b00100;
    n = 0;
    while (n < 50 && led[2] !== 1'b1) begin cyc(1); n++; end
    check("led2_latency", n, 6);
    cyc(30);
    check("idx2_beeps", beeps, 3);
    check("idx2_buzz_cycles", buzz_cycles, 9);
    check("idx2_order", ord_code, 3);
    check("idx2_busy_after", int'(busy), 0);
    pos_btn = 5'b00000;
    cyc(10);
    check("idx2_release_no_alert", ord_code, 3);

    // Simultaneous 0 and 3
    do_reset();
    pos_btn = 5'b01001;
    cyc(60);
    check("order_0_3", ord_code, 14);
    check("beeps_0_3", beeps, 5);

    // 0, 3 and seat together
    do_reset();
    pos_btn = 5'b11001;
    cyc(100);
`ifdef POS_SEAT_PRIORITY_EN
    check("order_seat_prio", ord_code, 514);
`else
    check("order_rr", ord_code, 145);
`endif
    check("beeps_0_3_4", beeps, 10);

    // Reset during second beep of index 1
    do_reset();
    pos_btn = 5'b00010;
    n = 0;
    while (n < 100 && beeps < 2) begin cyc(1); n++; end
    check("second_beep_reached", beeps, 2);
    check("buzz_on_before_reset", int'(buzz_en), 1);
    rst_n = 0;
    pos_btn = 0;
    #1;
    check("reset_drops_buzz", int'(buzz_en), 0);
    check("reset_drops_busy", int'({busy, cur_id}), 0);
    cyc(3);
    rst_n = 1;
    clear_book();
    cyc(40);
    check("no_beep_after_reset", beeps, 0);
    check("no_alert_after_reset", ord_code, 0);

    // Re-press of index 1 during its own alert
    do_reset();
    pos_btn = 5'b00010;
    n = 0;
    while (n < 50 && led[1] !== 1'b1) begin cyc(1); n++; end
    check("led1_rise_seen", int'(led[1]), 1);
    pos_btn = 5'b00000;
    n = 0;
    while (n < 50 && led[1] !== 1'b0) begin cyc(1); n++; end
    check("led1_fall_seen", int'(led[1]), 0);
    check("repress_during_alert", int'(busy), 1);
    pos_btn = 5'b00010;
    cyc(60);
    check("repeat_alert_order", ord_code, 22);
    check("repeat_alert_beeps", beeps, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
